// File: rtl/lcd_char_driver_if.sv
// Character-buffer write port between the message writer and the LCD driver.
// The writer drives this port and the driver receives it.
interface lcd_char_driver_if;
    logic       mem_wr_en;
    logic [4:0] mem_wr_addr;
    logic [7:0] mem_wr_data;

    modport master (output mem_wr_en, mem_wr_addr, mem_wr_data);
    modport slave  (input  mem_wr_en, mem_wr_addr, mem_wr_data);
endinterface

// File: rtl/lcd_char_driver.sv
// HD44780 2x16 character-LCD driver. It owns the 32-byte screen buffer, runs the power-up
// init sequence, and repaints both lines over the 8-bit bus whenever the buffer changes.
module lcd_char_driver #(
    parameter int unsigned POWERUP_CYC    = 750000,
    parameter int unsigned E_PULSE_CYC    = 12,
    parameter int unsigned CMD_WAIT_CYC   = 2500,
    parameter int unsigned CLEAR_WAIT_CYC = 82000
) (
    input  logic             clk,
    input  logic             rst,
    lcd_char_driver_if.slave mem_wr,
    output logic             lcd_rs,
    output logic             lcd_rw,
    output logic             lcd_e,
    output logic [7:0]       lcd_data,
    output logic             idle
);

    localparam logic [19:0] PWR_LAST   = 20'(POWERUP_CYC - 1);
    localparam logic [19:0] PULSE_LAST = 20'(E_PULSE_CYC - 1);
    localparam logic [19:0] CMD_LAST   = 20'(CMD_WAIT_CYC - 1);
    localparam logic [19:0] CLR_LAST   = 20'(CLEAR_WAIT_CYC - 1);

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT,
        IDLE,
        L1_ADDR,
        L1_CHARS,
        L2_ADDR,
        L2_CHARS
    } top_state_t;

    typedef enum logic [1:0] {
        B_SETUP,
        B_PULSE,
        B_HOLD,
        B_WAIT
    } byte_phase_t;

    top_state_t  top_q, top_d;
    byte_phase_t phase_q, phase_d;
    logic [19:0] cnt_q, cnt_d;
    logic [4:0]  idx_q, idx_d;
    logic        dirty_q, dirty_d;
    logic        start_byte;
    logic        byte_done;
    logic        nxt_rs;
    logic [7:0]  nxt_data;
    logic        e_d;
    logic        idle_d;
    logic [19:0] wait_last;
    logic [7:0]  char_buf [32];

    function automatic logic [7:0] init_cmd(input logic [2:0] i);
        case (i)
            3'd0, 3'd1, 3'd2: init_cmd = 8'h38;
            3'd3:             init_cmd = 8'h0C;
            3'd4:             init_cmd = 8'h01;
            3'd5:             init_cmd = 8'h06;
            default:          init_cmd = 8'h00;
        endcase
    endfunction

    // NOTE: this array is reset on purpose -- the panel must show spaces after reset,
    // so unlike a plain RAM every entry needs a defined value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) char_buf[i] <= 8'h20;
        end else if (mem_wr.mem_wr_en) begin
            char_buf[mem_wr.mem_wr_addr] <= mem_wr.mem_wr_data;
        end
    end

    // Clear-display needs the long settle time; everything else uses the short one.
    assign wait_last = (!lcd_rs && lcd_data == 8'h01) ? CLR_LAST : CMD_LAST;

    // NOTE: every signal gets a default at the top of the block, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        top_d      = top_q;
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        dirty_d    = dirty_q;
        start_byte = 1'b0;
        byte_done  = 1'b0;

        unique case (top_q)
            PWR_WAIT: begin
                if (cnt_q == PWR_LAST) begin
                    top_d      = INIT;
                    idx_d      = '0;
                    start_byte = 1'b1;
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end
            IDLE: begin
                if (dirty_q) begin
                    dirty_d    = 1'b0;
                    top_d      = L1_ADDR;
                    start_byte = 1'b1;
                end
            end
            default: begin
                unique case (phase_q)
                    B_SETUP: phase_d = B_PULSE;
                    B_PULSE: begin
                        if (cnt_q == PULSE_LAST) begin
                            phase_d = B_HOLD;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 20'd1;
                        end
                    end
                    B_HOLD: phase_d = B_WAIT;
                    B_WAIT: begin
                        if (cnt_q == wait_last) begin
                            cnt_d     = '0;
                            byte_done = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 20'd1;
                        end
                    end
                endcase
            end
        endcase

        // The index only reaches 16 through L2_ADDR and never advances past 31.
        if (byte_done) begin
            start_byte = 1'b1;
            unique case (top_q)
                INIT: begin
                    if (idx_q == 5'd5) begin
                        top_d      = IDLE;
                        idx_d      = '0;
                        start_byte = 1'b0;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
                L1_ADDR: begin
                    top_d = L1_CHARS;
                    idx_d = '0;
                end
                L1_CHARS: begin
                    if (idx_q == 5'd15) top_d = L2_ADDR;
                    else                idx_d = idx_q + 5'd1;
                end
                L2_ADDR: begin
                    top_d = L2_CHARS;
                    idx_d = 5'd16;
                end
                L2_CHARS: begin
                    if (idx_q == 5'd31) begin
                        top_d      = IDLE;
                        idx_d      = '0;
                        start_byte = 1'b0;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
                default: start_byte = 1'b0;
            endcase
        end

        // A write always wins over the clear in IDLE, so it is never lost.
        if (mem_wr.mem_wr_en) dirty_d = 1'b1;

        if (start_byte) begin
            phase_d = B_SETUP;
            cnt_d   = '0;
        end
    end

    // Byte presented at the next SETUP, sampled from the buffer before that edge's write.
    always_comb begin
        nxt_rs   = lcd_rs;
        nxt_data = lcd_data;
        unique case (top_d)
            INIT: begin
                nxt_rs   = 1'b0;
                nxt_data = init_cmd(idx_d[2:0]);
            end
            L1_ADDR: begin
                nxt_rs   = 1'b0;
                nxt_data = 8'h80;
            end
            L2_ADDR: begin
                nxt_rs   = 1'b0;
                nxt_data = 8'hC0;
            end
            L1_CHARS, L2_CHARS: begin
                nxt_rs   = 1'b1;
                nxt_data = char_buf[idx_d];
            end
            default: ;
        endcase
    end

    assign e_d = (phase_d == B_PULSE);
    // Arriving in IDLE with a refresh already pending is not reported as idle.
    assign idle_d = (top_d == IDLE) && !(top_q != IDLE && dirty_q);

    // NOTE: state and output registers use non-blocking assignments so every flop
    // samples the pre-edge values computed by the combinational logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            top_q    <= PWR_WAIT;
            phase_q  <= B_SETUP;
            cnt_q    <= '0;
            idx_q    <= '0;
            dirty_q  <= 1'b1;
            lcd_rs   <= 1'b0;
            lcd_e    <= 1'b0;
            lcd_data <= 8'h00;
            idle     <= 1'b0;
        end else begin
            top_q   <= top_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            dirty_q <= dirty_d;
            lcd_e   <= e_d;
            idle    <= idle_d;
            if (start_byte) begin
                lcd_rs   <= nxt_rs;
                lcd_data <= nxt_data;
            end
        end
    end

    assign lcd_rw = 1'b0;

endmodule

// File: tb/tb_lcd_char_driver.sv
// Directed bench for lcd_char_driver: init sequence, refresh passes, write collisions,
// mid-refresh reset and per-byte strobe timing, with hand-derived expectations.
module tb_lcd_char_driver;

    localparam int PWR = 20;
    localparam int EP  = 2;
    localparam int CW  = 4;
    localparam int CLW = 10;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         cyc;
    } lcd_byte_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       lcd_rs, lcd_rw, lcd_e, idle;
    logic [7:0] lcd_data;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int last_rise   = 0;
    int pass_start  = -1;

    lcd_byte_t  rx_q[$];
    logic [7:0] model   [32];
    logic [7:0] exp_img [32];

    lcd_char_driver_if wr_if ();

    lcd_char_driver #(
        .POWERUP_CYC   (PWR),
        .E_PULSE_CYC   (EP),
        .CMD_WAIT_CYC  (CW),
        .CLEAR_WAIT_CYC(CLW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .mem_wr  (wr_if),
        .lcd_rs  (lcd_rs),
        .lcd_rw  (lcd_rw),
        .lcd_e   (lcd_e),
        .lcd_data(lcd_data),
        .idle    (idle)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Bus monitor: records each byte at its lcd_e rise and checks strobe shape.
    initial begin
        logic       prev_e = 1'b0, prev_rs = 1'b0, cap_rs = 1'b0;
        logic [7:0] prev_data = 8'h00, cap_data = 8'h00;
        int         hi_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hi_cnt = 0;
                prev_e = 1'b0;
            end else if (lcd_e && !prev_e) begin
                check("setup_rs", lcd_rs, prev_rs);
                check("setup_data", lcd_data, prev_data);
                check("rw_low", lcd_rw, 1'b0);
                cap_rs   = lcd_rs;
                cap_data = lcd_data;
                hi_cnt   = 1;
                rx_q.push_back('{lcd_rs, lcd_data, cyc});
                if (!lcd_rs && lcd_data == 8'h80) pass_start = cyc;
            end else if (lcd_e) begin
                hi_cnt++;
                check("pulse_data", lcd_data, cap_data);
            end else if (prev_e) begin
                check("pulse_width", hi_cnt, EP);
                check("hold_rs", lcd_rs, cap_rs);
                check("hold_data", lcd_data, cap_data);
            end
            prev_e    = lcd_e;
            prev_rs   = lcd_rs;
            prev_data = lcd_data;
        end
    end

    function automatic logic [7:0] init_byte(input int i);
        case (i)
            3:       return 8'h0C;
            4:       return 8'h01;
            5:       return 8'h06;
            default: return 8'h38;
        endcase
    endfunction

    task automatic get_byte(output lcd_byte_t b);
        int waited = 0;
        while (rx_q.size() == 0 && waited < 400) begin
            @(posedge clk);
            waited++;
        end
        if (rx_q.size() == 0) begin
            check("byte_timeout", waited, 0);
            b = '{1'b0, 8'h00, cyc};
        end else begin
            b = rx_q.pop_front();
        end
    endtask

    task automatic expect_init(input int rel);
        lcd_byte_t b;
        int        prev = rel;
        for (int i = 0; i < 6; i++) begin
            get_byte(b);
            check($sformatf("init%0d_rs", i), b.rs, 1'b0);
            check($sformatf("init%0d_data", i), b.data, init_byte(i));
            check($sformatf("init%0d_gap", i), b.cyc - prev, (i == 0) ? 21 : ((i == 5) ? 14 : 8));
            prev = b.cyc;
        end
        last_rise = prev;
    endtask

    // One full refresh: 0x80, line 1, 0xC0, line 2; a first_gap of 0 skips the lead-in check.
    task automatic expect_pass(input int first_gap);
        lcd_byte_t  b;
        logic       ers;
        logic [7:0] edata;
        for (int j = 0; j < 34; j++) begin
            if (j == 0)       begin ers = 1'b0; edata = 8'h80;          end
            else if (j < 17)  begin ers = 1'b1; edata = exp_img[j - 1]; end
            else if (j == 17) begin ers = 1'b0; edata = 8'hC0;          end
            else              begin ers = 1'b1; edata = exp_img[j - 2]; end
            get_byte(b);
            check($sformatf("pass_b%0d_rs", j), b.rs, ers);
            check($sformatf("pass_b%0d_data", j), b.data, edata);
            if (j > 0 || first_gap > 0)
                check($sformatf("pass_b%0d_gap", j), b.cyc - last_rise, (j == 0) ? first_gap : 8);
            last_rise = b.cyc;
        end
    endtask

    task automatic expect_idle();
        int waited = 0;
        while (!idle && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("idle_rise", idle, 1'b1);
        check("idle_time", cyc - last_rise, 7);
        repeat (30) @(negedge clk);
        check("idle_hold", idle, 1'b1);
        check("no_extra_bytes", rx_q.size(), 0);
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        wr_if.mem_wr_en   = 1'b1;
        wr_if.mem_wr_addr = a;
        wr_if.mem_wr_data = d;
        model[a]          = d;
        @(negedge clk);
        wr_if.mem_wr_en   = 1'b0;
    endtask

    task automatic wait_pass_from(input int t0);
        int w = 0;
        while (pass_start < t0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("pass_started", pass_start >= t0, 1'b1);
    endtask

    task automatic wait_cycle(input int target);
        int w = 0;
        while (cyc < target && w < 400) begin
            @(negedge clk);
            w++;
        end
        check("reach_cycle", cyc, target);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rs"}, lcd_rs, 1'b0);
        check({tag, "_rw"}, lcd_rw, 1'b0);
        check({tag, "_e"}, lcd_e, 1'b0);
        check({tag, "_data"}, lcd_data, 8'h00);
        check({tag, "_idle"}, idle, 1'b0);
    endtask

    initial begin
        string msg = "Enter Combo";
        int    rel;
        int    t0;

        rst               = 1'b1;
        wr_if.mem_wr_en   = 1'b0;
        wr_if.mem_wr_addr = '0;
        wr_if.mem_wr_data = '0;
        for (int i = 0; i < 32; i++) model[i] = 8'h20;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");

        // Init plus the all-space refresh it triggers.
        rst = 1'b0;
        rel = cyc;
        expect_init(rel);
        exp_img = model;
        expect_pass(9);
        expect_idle();

        // Message written from IDLE; writes after the exit re-arm one more identical pass.
        for (int i = 0; i < 32; i++) begin
            wr_if.mem_wr_en   = 1'b1;
            wr_if.mem_wr_addr = 5'(i);
            wr_if.mem_wr_data = (i < msg.len()) ? msg[i] : 8'h20;
            model[i]          = wr_if.mem_wr_data;
            @(negedge clk);
            if (i == 0) check("idle_after_wr", idle, 1'b1);
            if (i == 1) check("idle_fall", idle, 1'b0);
        end
        wr_if.mem_wr_en = 1'b0;
        check("msg_e", model[0], 8'h45);
        exp_img = model;
        expect_pass(0);
        expect_pass(9);
        expect_idle();

        // Tries digits written during L1_CHARS: current pass plus one back-to-back pass.
        t0 = cyc;
        exp_img     = model;
        exp_img[16] = 8'h30;
        exp_img[17] = 8'h30;
        exp_img[18] = 8'h33;
        fork
            begin
                expect_pass(0);
                expect_pass(9);
            end
            begin
                wr(5'd31, 8'h20);
                wait_pass_from(t0);
                repeat (12) @(negedge clk);
                wr(5'd16, 8'h30);
                wr(5'd17, 8'h30);
                wr(5'd18, 8'h33);
            end
        join
        expect_idle();

        // Write to addr 5 during the SETUP cycle of char 5: old byte now, new byte next pass.
        t0 = cyc;
        exp_img = model;
        fork
            expect_pass(0);
            begin
                wr(5'd31, 8'h20);
                wait_pass_from(t0);
                wait_cycle(pass_start + 47);
                check("coll_setup_e", lcd_e, 1'b0);
                check("coll_setup_data", lcd_data, 8'h20);
                wr(5'd5, 8'h41);
            end
        join
        exp_img = model;
        check("coll_new", exp_img[5], 8'h41);
        expect_pass(9);
        expect_idle();

        // Reset in the WAIT of the first line-2 character.
        t0 = cyc;
        wr(5'd31, 8'h20);
        wait_pass_from(t0);
        wait_cycle(pass_start + 148);
        check("pre_rst_rs", lcd_rs, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_rst");
        repeat (2) @(negedge clk);
        rx_q.delete();
        for (int i = 0; i < 32; i++) model[i] = 8'h20;
        rst = 1'b0;
        rel = cyc;
        expect_init(rel);
        exp_img = model;
        expect_pass(9);
        expect_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
